// File: rtl/mem_port_arbiter_pkg.sv
// Shared types for the memory port arbiter: address/data widths, the
// requester id carried through the owner FIFO, and the memory request payload.
package mem_port_arbiter_pkg;

    localparam int unsigned AddrW = 32;
    localparam int unsigned DataW = 32;

    typedef logic [AddrW-1:0] addr_t;
    typedef logic [DataW-1:0] data_t;

    typedef enum logic {req_i = 1'b0, req_d = 1'b1} req_id_t;

    typedef struct packed {
        addr_t      addr;
        logic       we;
        data_t      wdata;
        logic [3:0] wstrb;
    } mem_req_t;

endpackage

// File: rtl/mem_port_arbiter_owner_fifo.sv
// Small in-order FIFO that remembers which requester owns each outstanding
// memory request.
//   clk, rst : clock and synchronous active-high reset
//   push/din : enqueue one element (caller never pushes while full)
//   pop/dout : dequeue the head element; dout shows the head combinationally
//   full     : Depth entries held
//   empty    : no entries held
// Depth need not be a power of two; pointers wrap explicitly at Depth-1.
module owner_fifo #(
    parameter int unsigned Depth = 2,
    parameter type         T     = logic
) (
    input  logic clk,
    input  logic rst,
    input  logic push,
    input  T     din,
    input  logic pop,
    output T     dout,
    output logic full,
    output logic empty
);

    localparam int unsigned     PtrW     = (Depth > 1) ? $clog2(Depth) : 1;
    localparam int unsigned     CntW     = $clog2(Depth + 1);
    localparam logic [PtrW-1:0] LastPtr  = PtrW'(Depth - 1);
    localparam logic [CntW-1:0] DepthCnt = CntW'(Depth);

    T                mem_q [Depth];
    logic [PtrW-1:0] wr_ptr_q, wr_ptr_d;
    logic [PtrW-1:0] rd_ptr_q, rd_ptr_d;
    logic [CntW-1:0] cnt_q, cnt_d;
    logic            do_push_s;
    logic            do_pop_s;

    // Advance a pointer, wrapping at the last slot rather than at a power of two.
    function automatic logic [PtrW-1:0] ptr_inc(input logic [PtrW-1:0] p);
        if (p == LastPtr) begin
            return {PtrW{1'b0}};
        end else begin
            return p + PtrW'(1);
        end
    endfunction

    assign full      = (cnt_q == DepthCnt);
    assign empty     = (cnt_q == {CntW{1'b0}});
    assign do_push_s = push && !full;
    assign do_pop_s  = pop && !empty;
    assign dout      = mem_q[rd_ptr_q];

    // Next-state for pointers and occupancy.
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        cnt_d    = cnt_q;
        if (do_push_s) begin
            wr_ptr_d = ptr_inc(wr_ptr_q);
        end else begin
            wr_ptr_d = wr_ptr_q;
        end
        if (do_pop_s) begin
            rd_ptr_d = ptr_inc(rd_ptr_q);
        end else begin
            rd_ptr_d = rd_ptr_q;
        end
        case ({do_push_s, do_pop_s})
            2'b10:   cnt_d = cnt_q + CntW'(1);
            2'b01:   cnt_d = cnt_q - CntW'(1);
            default: cnt_d = cnt_q;
        endcase
    end

    // Pointer and occupancy registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q <= {PtrW{1'b0}};
            rd_ptr_q <= {PtrW{1'b0}};
            cnt_q    <= {CntW{1'b0}};
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            cnt_q    <= cnt_d;
        end
    end

    // Storage; contents need no reset because occupancy guards every read.
    always_ff @(posedge clk) begin
        if (do_push_s) begin
            mem_q[wr_ptr_q] <= din;
        end
    end

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares one memory port between instruction fetch (I) and load/store (D).
//   i_req_* / d_req_* : requester handshakes and payloads
//   i_rsp_* / d_rsp_* : responses routed back to the owner of the FIFO head
//   mem_req_*         : forwarded request, one per cycle
//   mem_rsp_*         : in-order memory response, never back-pressured
//   rsp_err           : sticky; a response arrived with nothing outstanding
// D wins ties unless I has watched StarveLimit consecutive D grants. A request
// stalled by mem_req_ready=0 locks the grant so the payload cannot change
// under the memory until it is accepted.
module mem_port_arbiter
    import mem_port_arbiter_pkg::*;
#(
    parameter int unsigned MaxOutstanding = 2,
    parameter int unsigned StarveLimit    = 4
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       i_req_valid,
    output logic       i_req_ready,
    input  addr_t      i_req_addr,
    output logic       i_rsp_valid,
    output data_t      i_rsp_data,
    input  logic       d_req_valid,
    output logic       d_req_ready,
    input  addr_t      d_req_addr,
    input  logic       d_req_we,
    input  data_t      d_req_wdata,
    input  logic [3:0] d_req_wstrb,
    output logic       d_rsp_valid,
    output data_t      d_rsp_data,
    output logic       mem_req_valid,
    input  logic       mem_req_ready,
    output mem_req_t   mem_req,
    input  logic       mem_rsp_valid,
    input  data_t      mem_rsp_data,
    output logic       rsp_err
);

    localparam int unsigned   SW        = $clog2(StarveLimit + 1);
    localparam logic [SW-1:0] StarveMax = SW'(StarveLimit);

    logic          lock_vld_q, lock_vld_d;
    req_id_t       lock_id_q, lock_id_d;
    logic [SW-1:0] starve_cnt_q, starve_cnt_d;
    logic          rsp_err_q, rsp_err_d;

    logic          sel_valid_s;
    req_id_t       sel_id_s;
    logic          fifo_full_s;
    logic          fifo_empty_s;
    req_id_t       head_id_s;
    logic          hs_s;
    logic          pop_s;

    // Candidate selection: a held lock overrides both priority and starvation.
    always_comb begin
        sel_valid_s = 1'b0;
        sel_id_s    = req_d;
        if (lock_vld_q) begin
            sel_id_s    = lock_id_q;
            sel_valid_s = (lock_id_q == req_i) ? i_req_valid : d_req_valid;
        end else if (i_req_valid && d_req_valid) begin
            sel_valid_s = 1'b1;
            sel_id_s    = (starve_cnt_q == StarveMax) ? req_i : req_d;
        end else if (d_req_valid) begin
            sel_valid_s = 1'b1;
            sel_id_s    = req_d;
        end else if (i_req_valid) begin
            sel_valid_s = 1'b1;
            sel_id_s    = req_i;
        end else begin
            sel_valid_s = 1'b0;
            sel_id_s    = req_d;
        end
    end

    assign mem_req_valid = !rst && sel_valid_s && !fifo_full_s;
    assign hs_s          = mem_req_valid && mem_req_ready;
    assign i_req_ready   = hs_s && (sel_id_s == req_i);
    assign d_req_ready   = hs_s && (sel_id_s == req_d);

    // Payload mux; fetches are reads with zeroed write fields.
    always_comb begin
        mem_req = '{addr: d_req_addr, we: d_req_we, wdata: d_req_wdata, wstrb: d_req_wstrb};
        if (sel_id_s == req_i) begin
            mem_req.addr  = i_req_addr;
            mem_req.we    = 1'b0;
            mem_req.wdata = {DataW{1'b0}};
            mem_req.wstrb = 4'h0;
        end else begin
            mem_req.addr  = d_req_addr;
        end
    end

    assign pop_s       = !rst && mem_rsp_valid && !fifo_empty_s;
    assign i_rsp_valid = pop_s && (head_id_s == req_i);
    assign d_rsp_valid = pop_s && (head_id_s == req_d);
    assign i_rsp_data  = mem_rsp_data;
    assign d_rsp_data  = mem_rsp_data;
    assign rsp_err     = rsp_err_q;

    owner_fifo #(
        .Depth (MaxOutstanding),
        .T     (req_id_t)
    ) u_owner_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (hs_s),
        .din   (sel_id_s),
        .pop   (pop_s),
        .dout  (head_id_s),
        .full  (fifo_full_s),
        .empty (fifo_empty_s)
    );

    // Next-state for lock, starvation counter and error flag.
    always_comb begin
        // A stalled offer locks; acceptance or a dropped valid releases it.
        lock_vld_d   = mem_req_valid && !mem_req_ready;
        lock_id_d    = lock_vld_d ? sel_id_s : lock_id_q;
        starve_cnt_d = starve_cnt_q;
        if (!i_req_valid || i_req_ready) begin
            starve_cnt_d = {SW{1'b0}};
        end else if (d_req_ready && (starve_cnt_q != StarveMax)) begin
            starve_cnt_d = starve_cnt_q + SW'(1);
        end else begin
            starve_cnt_d = starve_cnt_q;
        end
        rsp_err_d = rsp_err_q || (mem_rsp_valid && fifo_empty_s);
    end

    // Control registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            lock_vld_q   <= 1'b0;
            lock_id_q    <= req_i;
            starve_cnt_q <= {SW{1'b0}};
            rsp_err_q    <= 1'b0;
        end else begin
            lock_vld_q   <= lock_vld_d;
            lock_id_q    <= lock_id_d;
            starve_cnt_q <= starve_cnt_d;
            rsp_err_q    <= rsp_err_d;
        end
    end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter with hand-computed expectations.
module tb_mem_port_arbiter;
    import mem_port_arbiter_pkg::*;

    logic       clk;
    logic       rst;
    logic       i_req_valid;
    logic       i_req_ready;
    addr_t      i_req_addr;
    logic       i_rsp_valid;
    data_t      i_rsp_data;
    logic       d_req_valid;
    logic       d_req_ready;
    addr_t      d_req_addr;
    logic       d_req_we;
    data_t      d_req_wdata;
    logic [3:0] d_req_wstrb;
    logic       d_rsp_valid;
    data_t      d_rsp_data;
    logic       mem_req_valid;
    logic       mem_req_ready;
    mem_req_t   mem_req;
    logic       mem_rsp_valid;
    data_t      mem_rsp_data;
    logic       rsp_err;

    int n_checks = 0;
    int n_errors = 0;

    mem_port_arbiter #(
        .MaxOutstanding (2),
        .StarveLimit    (4)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .i_req_valid   (i_req_valid),
        .i_req_ready   (i_req_ready),
        .i_req_addr    (i_req_addr),
        .i_rsp_valid   (i_rsp_valid),
        .i_rsp_data    (i_rsp_data),
        .d_req_valid   (d_req_valid),
        .d_req_ready   (d_req_ready),
        .d_req_addr    (d_req_addr),
        .d_req_we      (d_req_we),
        .d_req_wdata   (d_req_wdata),
        .d_req_wstrb   (d_req_wstrb),
        .d_rsp_valid   (d_rsp_valid),
        .d_rsp_data    (d_rsp_data),
        .mem_req_valid (mem_req_valid),
        .mem_req_ready (mem_req_ready),
        .mem_req       (mem_req),
        .mem_rsp_valid (mem_rsp_valid),
        .mem_rsp_data  (mem_rsp_data),
        .rsp_err       (rsp_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Count one comparison and report it if it disagrees.
    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        i_req_valid   = 1'b0;
        i_req_addr    = 32'h0;
        d_req_valid   = 1'b0;
        d_req_addr    = 32'h0;
        d_req_we      = 1'b0;
        d_req_wdata   = 32'h0;
        d_req_wstrb   = 4'h0;
        mem_req_ready = 1'b1;
        mem_rsp_valid = 1'b0;
        mem_rsp_data  = 32'h0;
    endtask

    // Safety net so the run always ends.
    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        logic [9:0]  grant_i_tbl;
        logic [31:0] i_cnt;
        logic [31:0] d_cnt;
        logic        exp_i;
        logic        prev_i;

        // Reset and idle state.
        idle();
        rst = 1'b1;
        next_cycle();
        next_cycle();
        rst = 1'b0;
        #2;
        check("rst_mvalid", mem_req_valid, 1'b0);
        check("rst_iready", i_req_ready, 1'b0);
        check("rst_dready", d_req_ready, 1'b0);
        check("rst_irsp", i_rsp_valid, 1'b0);
        check("rst_drsp", d_rsp_valid, 1'b0);
        check("rst_err", rsp_err, 1'b0);
        next_cycle();

        // Single fetch, response three cycles later.
        i_req_valid = 1'b1;
        i_req_addr  = 32'h100;
        #2;
        check("t1_mvalid", mem_req_valid, 1'b1);
        check("t1_addr", mem_req.addr, 32'h100);
        check("t1_we", mem_req.we, 1'b0);
        check("t1_iready", i_req_ready, 1'b1);
        check("t1_dready", d_req_ready, 1'b0);
        next_cycle();
        i_req_valid = 1'b0;
        next_cycle();
        next_cycle();
        mem_rsp_valid = 1'b1;
        mem_rsp_data  = 32'hDEADBEEF;
        #2;
        check("t1_irsp", i_rsp_valid, 1'b1);
        check("t1_idata", i_rsp_data, 32'hDEADBEEF);
        check("t1_drsp", d_rsp_valid, 1'b0);
        next_cycle();
        idle();
        next_cycle();

        // Both valid for ten cycles: D,D,D,D,I,D,D,D,D,I with in-order routing.
        grant_i_tbl = 10'b10_0001_0000;
        i_cnt = 32'h0;
        d_cnt = 32'h0;
        for (int k = 0; k < 11; k++) begin
            i_req_valid   = (k < 10);
            d_req_valid   = (k < 10);
            i_req_addr    = 32'h300 + i_cnt;
            d_req_addr    = 32'h200 + d_cnt;
            d_req_wstrb   = 4'hF;
            mem_rsp_valid = (k > 0);
            mem_rsp_data  = 32'hA000 + 32'(k);
            #2;
            if (k < 10) begin
                exp_i = grant_i_tbl[k];
                check($sformatf("t2_iready_%0d", k), i_req_ready, exp_i);
                check($sformatf("t2_dready_%0d", k), d_req_ready, !exp_i);
                check($sformatf("t2_addr_%0d", k), mem_req.addr,
                      exp_i ? (32'h300 + i_cnt) : (32'h200 + d_cnt));
                if (exp_i) i_cnt = i_cnt + 32'h1;
                else       d_cnt = d_cnt + 32'h1;
            end
            if (k > 0) begin
                prev_i = grant_i_tbl[k-1];
                check($sformatf("t2_irsp_%0d", k), i_rsp_valid, prev_i);
                check($sformatf("t2_drsp_%0d", k), d_rsp_valid, !prev_i);
                check($sformatf("t2_rdata_%0d", k), prev_i ? i_rsp_data : d_rsp_data,
                      32'hA000 + 32'(k));
            end
            next_cycle();
        end
        idle();
        next_cycle();

        // Grant lock: I stalled three cycles, D arrives meanwhile.
        mem_req_ready = 1'b0;
        i_req_valid   = 1'b1;
        i_req_addr    = 32'h400;
        #2;
        check("t3_c0_mvalid", mem_req_valid, 1'b1);
        check("t3_c0_iready", i_req_ready, 1'b0);
        next_cycle();
        d_req_valid = 1'b1;
        d_req_addr  = 32'h500;
        d_req_we    = 1'b1;
        d_req_wdata = 32'h55;
        d_req_wstrb = 4'hF;
        #2;
        check("t3_c1_addr", mem_req.addr, 32'h400);
        check("t3_c1_we", mem_req.we, 1'b0);
        check("t3_c1_dready", d_req_ready, 1'b0);
        next_cycle();
        #2;
        check("t3_c2_addr", mem_req.addr, 32'h400);
        next_cycle();
        mem_req_ready = 1'b1;
        #2;
        check("t3_c3_iready", i_req_ready, 1'b1);
        check("t3_c3_dready", d_req_ready, 1'b0);
        next_cycle();
        i_req_valid = 1'b0;
        #2;
        check("t3_c4_dready", d_req_ready, 1'b1);
        check("t3_c4_addr", mem_req.addr, 32'h500);
        check("t3_c4_we", mem_req.we, 1'b1);
        check("t3_c4_wdata", mem_req.wdata, 32'h55);
        next_cycle();

        // FIFO now full (I, D): next request stalls until a pop retires.
        d_req_addr = 32'h600;
        d_req_we   = 1'b0;
        #2;
        check("t4_full_mvalid", mem_req_valid, 1'b0);
        check("t4_full_dready", d_req_ready, 1'b0);
        next_cycle();
        mem_rsp_valid = 1'b1;
        mem_rsp_data  = 32'h1111;
        #2;
        check("t4_pop_irsp", i_rsp_valid, 1'b1);
        check("t4_pop_drsp", d_rsp_valid, 1'b0);
        check("t4_pop_mvalid", mem_req_valid, 1'b0);
        next_cycle();
        mem_rsp_valid = 1'b0;
        #2;
        check("t4_issue_mvalid", mem_req_valid, 1'b1);
        check("t4_issue_dready", d_req_ready, 1'b1);
        check("t4_issue_addr", mem_req.addr, 32'h600);
        next_cycle();
        d_req_valid   = 1'b0;
        mem_rsp_valid = 1'b1;
        mem_rsp_data  = 32'h2222;
        #2;
        check("t4_rsp2_drsp", d_rsp_valid, 1'b1);
        check("t4_rsp2_data", d_rsp_data, 32'h2222);
        next_cycle();
        mem_rsp_data = 32'h3333;
        #2;
        check("t4_rsp3_drsp", d_rsp_valid, 1'b1);
        check("t4_rsp3_irsp", i_rsp_valid, 1'b0);
        next_cycle();
        idle();
        #2;
        check("t4_err_clean", rsp_err, 1'b0);
        next_cycle();

        // Stray response with empty FIFO: dropped, sticky error, cleared by reset.
        mem_rsp_valid = 1'b1;
        mem_rsp_data  = 32'h7777;
        #2;
        check("t5_irsp", i_rsp_valid, 1'b0);
        check("t5_drsp", d_rsp_valid, 1'b0);
        next_cycle();
        mem_rsp_valid = 1'b0;
        #2;
        check("t5_err_set", rsp_err, 1'b1);
        next_cycle();
        next_cycle();
        #2;
        check("t5_err_held", rsp_err, 1'b1);
        rst = 1'b1;
        next_cycle();
        rst = 1'b0;
        #2;
        check("t5_err_clr", rsp_err, 1'b0);
        next_cycle();

        // Reset with two outstanding: both late responses are orphans.
        i_req_valid = 1'b1;
        i_req_addr  = 32'h700;
        #2;
        check("t6_iready", i_req_ready, 1'b1);
        next_cycle();
        i_req_valid = 1'b0;
        d_req_valid = 1'b1;
        d_req_addr  = 32'h800;
        #2;
        check("t6_dready", d_req_ready, 1'b1);
        next_cycle();
        idle();
        rst = 1'b1;
        next_cycle();
        rst = 1'b0;
        mem_rsp_valid = 1'b1;
        mem_rsp_data  = 32'h9999;
        #2;
        check("t6_r1_irsp", i_rsp_valid, 1'b0);
        check("t6_r1_drsp", d_rsp_valid, 1'b0);
        check("t6_r1_err_pre", rsp_err, 1'b0);
        next_cycle();
        #2;
        check("t6_r2_irsp", i_rsp_valid, 1'b0);
        check("t6_r2_drsp", d_rsp_valid, 1'b0);
        check("t6_r2_err", rsp_err, 1'b1);
        next_cycle();
        idle();
        #2;
        check("t6_err_held", rsp_err, 1'b1);
        check("t6_mvalid", mem_req_valid, 1'b0);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
